// File: rtl/l2_responder_pkg.sv
// Shared L2 definitions: request/response op encodings, responder FSM states,
// the queued request record and the bytewise line merge helper.
package l2_responder_pkg;

    localparam int unsigned LINE_BITS = 512;
    localparam int unsigned MASK_BITS = 64;
    localparam int unsigned ADDR_BITS = 26;
    localparam int unsigned STRANDS   = 4;

    typedef enum logic [2:0] {
        OP_LOAD       = 3'd0,
        OP_STORE      = 3'd1,
        OP_FLUSH      = 3'd2,
        OP_INVALIDATE = 3'd3,
        OP_LOAD_SYNC  = 3'd4,
        OP_STORE_SYNC = 3'd5,
        OP_RSVD6      = 3'd6,
        OP_RSVD7      = 3'd7
    } l2_op_e;

    typedef enum logic [1:0] {
        RSP_LOAD       = 2'd0,
        RSP_STORE      = 2'd1,
        RSP_FLUSH      = 2'd2,
        RSP_INVALIDATE = 2'd3
    } l2_rsp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_RESPOND = 2'd2
    } l2_state_e;

    typedef struct packed {
        logic [1:0]           strand;
        logic [1:0]           unit;
        l2_op_e               op;
        logic [1:0]           way;
        logic [ADDR_BITS-1:0] address;
        logic [LINE_BITS-1:0] data;
        logic [MASK_BITS-1:0] mask;
    } l2_req_t;

    function automatic logic [LINE_BITS-1:0] merge_line(
        input logic [LINE_BITS-1:0] old_line,
        input logic [LINE_BITS-1:0] new_line,
        input logic [MASK_BITS-1:0] mask
    );
        logic [LINE_BITS-1:0] result;
        for (int unsigned i = 0; i < MASK_BITS; i++) begin
            result[8*i +: 8] = mask[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_line_ram.sv
// Backing line store: synchronous one-cycle read, single write port, and a
// same-cycle write-to-read bypass so a colliding read returns the new data.
module l2_line_ram #(
    parameter int unsigned LINE_COUNT = 64,
    parameter int unsigned IDX_W      = $clog2(LINE_COUNT)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic [511:0]     rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [511:0]     wr_data
);

    logic [511:0] mem [LINE_COUNT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_index == rd_index)) ? wr_data : mem[rd_index];
        end
    end

endmodule

// File: rtl/l2_responder.sv
// L2 responder: queues requests in a FIFO and serves them one at a time through
// IDLE -> READ -> RESPOND against a line RAM, with per-strand reservations.
module l2_responder
    import l2_responder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LINE_COUNT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         l2req_valid,
    output logic         l2req_ack,
    input  logic [1:0]   l2req_strand,
    input  logic [1:0]   l2req_unit,
    input  logic [2:0]   l2req_op,
    input  logic [1:0]   l2req_way,
    input  logic [25:0]  l2req_address,
    input  logic [511:0] l2req_data,
    input  logic [63:0]  l2req_mask,
    output logic         l2rsp_valid,
    output logic         l2rsp_status,
    output logic [1:0]   l2rsp_unit,
    output logic [1:0]   l2rsp_strand,
    output logic [1:0]   l2rsp_op,
    output logic         l2rsp_update,
    output logic [1:0]   l2rsp_way,
    output logic [511:0] l2rsp_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned IDX_W = $clog2(LINE_COUNT);

    l2_state_e state, state_next;

    l2_req_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, push, pop;
    l2_req_t          new_req, head, cur;

    logic [511:0]     line_q, ram_rdata, merged;
    logic             do_write, set_res, sc_ok;
    logic [3:0]       res_valid;
    logic [25:0]      res_addr [STRANDS];

    // Request queue
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign l2req_ack  = reset_n && l2req_valid && !fifo_full;
    assign push       = l2req_ack;
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_comb begin
        new_req.strand  = l2req_strand;
        new_req.unit    = l2req_unit;
        new_req.op      = l2_op_e'(l2req_op);
        new_req.way     = l2req_way;
        new_req.address = l2req_address;
        new_req.data    = l2req_data;
        new_req.mask    = l2req_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= new_req;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (!fifo_empty) state_next = ST_READ;
            ST_READ:    state_next = ST_RESPOND;
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath: request popped in IDLE, line captured in READ
    always_ff @(posedge clk) begin
        if (pop)               cur    <= head;
        if (state == ST_READ)  line_q <= ram_rdata;
    end

    l2_line_ram #(
        .LINE_COUNT (LINE_COUNT),
        .IDX_W      (IDX_W)
    ) u_line_ram (
        .clk      (clk),
        .rd_en    (pop),
        .rd_index (head.address[IDX_W-1:0]),
        .rd_data  (ram_rdata),
        .wr_en    (do_write),
        .wr_index (cur.address[IDX_W-1:0]),
        .wr_data  (merged)
    );

    assign merged = merge_line(line_q, cur.data, cur.mask);
    assign sc_ok  = res_valid[cur.strand] && (res_addr[cur.strand] == cur.address);

    // FSM outputs: response fields and write/reservation strobes exist only in RESPOND
    always_comb begin
        l2rsp_valid  = 1'b0;
        l2rsp_status = 1'b0;
        l2rsp_update = 1'b0;
        l2rsp_op     = '0;
        l2rsp_unit   = '0;
        l2rsp_strand = '0;
        l2rsp_way    = '0;
        l2rsp_data   = line_q;
        do_write     = 1'b0;
        set_res      = 1'b0;
        if (state == ST_RESPOND) begin
            l2rsp_valid  = 1'b1;
            l2rsp_unit   = cur.unit;
            l2rsp_strand = cur.strand;
            l2rsp_way    = cur.way;
            l2rsp_status = 1'b1;
            unique case (cur.op)
                OP_LOAD:       l2rsp_op = RSP_LOAD;
                OP_LOAD_SYNC: begin
                    l2rsp_op = RSP_LOAD;
                    set_res  = 1'b1;
                end
                OP_STORE: begin
                    l2rsp_op = RSP_STORE;
                    do_write = 1'b1;
                end
                OP_STORE_SYNC: begin
                    l2rsp_op     = RSP_STORE;
                    do_write     = sc_ok;
                    l2rsp_status = sc_ok;
                end
                OP_FLUSH:      l2rsp_op = RSP_FLUSH;
                OP_INVALIDATE: l2rsp_op = RSP_INVALIDATE;
                default: begin
                    l2rsp_op     = RSP_LOAD;
                    l2rsp_status = 1'b0;
                end
            endcase
            l2rsp_update = (l2rsp_op == RSP_STORE) && l2rsp_status;
            if (do_write) l2rsp_data = merged;
        end
    end

    // Any successful write kills every matching reservation, the writer's included
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= '0;
            for (int unsigned i = 0; i < STRANDS; i++) res_addr[i] <= '0;
        end else begin
            if (set_res) begin
                res_valid[cur.strand] <= 1'b1;
                res_addr[cur.strand]  <= cur.address;
            end
            if (do_write) begin
                for (int unsigned i = 0; i < STRANDS; i++) begin
                    if (res_addr[i] == cur.address) res_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder: a reference model predicts each response at
// accept time into a queue, which the response monitor drains in order.
module tb_l2_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         l2req_valid;
    logic         l2req_ack;
    logic [1:0]   l2req_strand, l2req_unit, l2req_way;
    logic [2:0]   l2req_op;
    logic [25:0]  l2req_address;
    logic [511:0] l2req_data;
    logic [63:0]  l2req_mask;
    logic         l2rsp_valid, l2rsp_status, l2rsp_update;
    logic [1:0]   l2rsp_unit, l2rsp_strand, l2rsp_op, l2rsp_way;
    logic [511:0] l2rsp_data;

    always #5 clk = ~clk;

    l2_responder #(
        .FIFO_DEPTH (4),
        .LINE_COUNT (64)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .l2req_valid   (l2req_valid),
        .l2req_ack     (l2req_ack),
        .l2req_strand  (l2req_strand),
        .l2req_unit    (l2req_unit),
        .l2req_op      (l2req_op),
        .l2req_way     (l2req_way),
        .l2req_address (l2req_address),
        .l2req_data    (l2req_data),
        .l2req_mask    (l2req_mask),
        .l2rsp_valid   (l2rsp_valid),
        .l2rsp_status  (l2rsp_status),
        .l2rsp_unit    (l2rsp_unit),
        .l2rsp_strand  (l2rsp_strand),
        .l2rsp_op      (l2rsp_op),
        .l2rsp_update  (l2rsp_update),
        .l2rsp_way     (l2rsp_way),
        .l2rsp_data    (l2rsp_data)
    );

    localparam logic [2:0] LD = 3'd0, ST = 3'd1, FL = 3'd2, INV = 3'd3, LDS = 3'd4, STS = 3'd5;
    localparam logic [63:0] ALL = '1;

    typedef struct {
        logic [1:0]   op;
        logic         status;
        logic         update;
        logic [1:0]   unit;
        logic [1:0]   strand;
        logic [1:0]   way;
        logic [511:0] data;
        bit           chk_data;
        int           exp_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_rsp = -100;
    logic [511:0] mem_m [64];
    bit           known_m [64];
    bit           rv_m [4];
    logic [25:0]  ra_m [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [511:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    // Serial reference: requests execute in acceptance order, so predicting at accept is exact
    task automatic model_push(input logic [1:0] strand, input logic [1:0] unit, input logic [2:0] op,
                              input logic [1:0] way, input logic [25:0] addr,
                              input logic [511:0] data, input logic [63:0] mask);
        exp_t         x;
        int           idx = int'(addr[5:0]);
        logic [511:0] old_line, mrg;
        bit           wr = 0;
        old_line = mem_m[idx];
        for (int i = 0; i < 64; i++) mrg[8*i +: 8] = mask[i] ? data[8*i +: 8] : old_line[8*i +: 8];
        x.unit = unit; x.strand = strand; x.way = way;
        x.data = old_line; x.chk_data = known_m[idx];
        x.status = 1'b1; x.op = 2'd0;
        case (op)
            LD:  x.op = 2'd0;
            LDS: begin x.op = 2'd0; rv_m[strand] = 1; ra_m[strand] = addr; end
            ST:  begin x.op = 2'd1; wr = 1; end
            FL:  x.op = 2'd2;
            INV: x.op = 2'd3;
            STS: begin
                x.op = 2'd1;
                wr = rv_m[strand] && (ra_m[strand] == addr);
                x.status = wr;
                if (!wr) x.chk_data = 0;
            end
            default: begin x.op = 2'd0; x.status = 1'b0; end
        endcase
        if (wr) begin
            x.chk_data = known_m[idx] || (mask == ALL);
            x.data = mrg;
            mem_m[idx] = mrg;
            known_m[idx] = x.chk_data;
            for (int s = 0; s < 4; s++) if (ra_m[s] == addr) rv_m[s] = 0;
        end
        x.update = (x.op == 2'd1) && x.status;
        x.exp_cyc = (cyc + 3 > last_rsp + 3) ? cyc + 3 : last_rsp + 3;
        last_rsp = x.exp_cyc;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [1:0] strand, input logic [1:0] unit, input logic [2:0] op,
                         input logic [1:0] way, input logic [25:0] addr,
                         input logic [511:0] data, input logic [63:0] mask);
        l2req_strand = strand; l2req_unit = unit; l2req_op = op; l2req_way = way;
        l2req_address = addr; l2req_data = data; l2req_mask = mask;
    endtask

    task automatic issue(input logic [1:0] strand, input logic [1:0] unit, input logic [2:0] op,
                         input logic [1:0] way, input logic [25:0] addr,
                         input logic [511:0] data, input logic [63:0] mask, input bit predict);
        int waited = 0;
        @(negedge clk);
        drive(strand, unit, op, way, addr, data, mask);
        l2req_valid = 1'b1;
        #1;
        while (l2req_ack !== 1'b1) begin
            waited++;
            if (waited > 200) begin
                n_err++;
                $display("FAIL ack_timeout observed=ack_low required=ack_high");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
            #1;
        end
        if (predict) model_push(strand, unit, op, way, addr, data, mask);
        @(posedge clk);
        #1;
        l2req_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain_timeout observed=%0d_pending required=0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Response monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n === 1'b1 && l2rsp_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_rsp observed=valid required=no_response");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_op",     512'(l2rsp_op),     512'(e.op));
                check("rsp_status", 512'(l2rsp_status), 512'(e.status));
                check("rsp_update", 512'(l2rsp_update), 512'(e.update));
                check("rsp_unit",   512'(l2rsp_unit),   512'(e.unit));
                check("rsp_strand", 512'(l2rsp_strand), 512'(e.strand));
                check("rsp_way",    512'(l2rsp_way),    512'(e.way));
                check("rsp_cycle",  512'(cyc),          512'(e.exp_cyc));
                if (e.chk_data) check("rsp_data", l2rsp_data, e.data);
            end
        end
    end

    logic [2:0] s_op   [8];
    logic [7:0] s_byte [8];
    logic [63:0] s_mask [8];
    int accepted, first_stall_at, waited;

    initial begin
        reset_n = 1'b1;
        l2req_valid = 1'b0;
        drive(2'd0, 2'd0, LD, 2'd0, 26'd0, '0, '0);
        #2 reset_n = 1'b0;
        l2req_valid = 1'b1;
        #1;
        check("rst_valid",  512'(l2rsp_valid),  '0);
        check("rst_status", 512'(l2rsp_status), '0);
        check("rst_update", 512'(l2rsp_update), '0);
        check("rst_op",     512'(l2rsp_op),     '0);
        check("rst_unit",   512'(l2rsp_unit),   '0);
        check("rst_strand", 512'(l2rsp_strand), '0);
        check("rst_way",    512'(l2rsp_way),    '0);
        check("rst_ack",    512'(l2req_ack),    '0);
        l2req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Full-line store then load, then single-byte merge
        issue(2'd0, 2'd1, ST, 2'd2, 26'd5, fill(8'hAA), ALL, 1);
        issue(2'd0, 2'd2, LD, 2'd1, 26'd5, '0, '0, 1);
        drain();
        issue(2'd1, 2'd3, ST, 2'd3, 26'd5, fill(8'h55), 64'h1, 1);
        issue(2'd1, 2'd0, LD, 2'd0, 26'd5, '0, '0, 1);
        drain();

        // Reservation success, then repeat fails and leaves the line alone
        issue(2'd1, 2'd0, LDS, 2'd0, 26'd9, '0, '0, 1);
        issue(2'd1, 2'd0, STS, 2'd1, 26'd9, fill(8'h11), ALL, 1);
        issue(2'd1, 2'd0, STS, 2'd1, 26'd9, fill(8'h22), ALL, 1);
        issue(2'd1, 2'd0, LD,  2'd1, 26'd9, '0, '0, 1);
        drain();

        // Another strand's store kills strand 0's reservation
        issue(2'd0, 2'd1, LDS, 2'd0, 26'd3, '0, '0, 1);
        issue(2'd2, 2'd1, ST,  2'd0, 26'd3, fill(8'h33), ALL, 1);
        issue(2'd0, 2'd1, STS, 2'd0, 26'd3, fill(8'h44), ALL, 1);
        issue(2'd0, 2'd1, LD,  2'd0, 26'd3, '0, '0, 1);
        drain();

        // Flush, invalidate and reserved ops leave state unchanged
        issue(2'd3, 2'd2, FL,   2'd1, 26'd5, '0, '0, 1);
        issue(2'd3, 2'd2, INV,  2'd2, 26'd5, '0, '0, 1);
        issue(2'd3, 2'd2, 3'd6, 2'd3, 26'd5, fill(8'h99), ALL, 1);
        issue(2'd3, 2'd2, 3'd7, 2'd0, 26'd5, fill(8'h99), ALL, 1);
        issue(2'd3, 2'd2, LD,   2'd0, 26'd5, '0, '0, 1);
        drain();

        // Eight gapless requests to one line
        s_op   = '{ST, LD, ST, LDS, STS, STS, LD, INV};
        s_byte = '{8'h10, 8'h00, 8'h21, 8'h00, 8'h32, 8'h43, 8'h00, 8'h00};
        s_mask = '{ALL, 64'h0, 64'hF0, 64'h0, 64'hFF00_0000_0000_0000, ALL, 64'h0, 64'h0};
        accepted = 0;
        first_stall_at = -1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive(2'd3, 2'(k), s_op[k], 2'(~k), 26'd20, fill(s_byte[k]), s_mask[k]);
            l2req_valid = 1'b1;
            #1;
            waited = 0;
            while (l2req_ack !== 1'b1 && waited < 200) begin
                if (first_stall_at < 0) first_stall_at = accepted;
                waited++;
                @(negedge clk);
                #1;
            end
            model_push(2'd3, 2'(k), s_op[k], 2'(~k), 26'd20, fill(s_byte[k]), s_mask[k]);
            accepted++;
            @(negedge clk);
        end
        l2req_valid = 1'b0;
        check("stream_first_stall", 512'(first_stall_at), 512'(6));
        drain();

        // Reset while a store is in READ: no response, no write, queue empty afterwards
        issue(2'd0, 2'd0, ST, 2'd0, 26'd12, fill(8'h66), ALL, 1);
        drain();
        issue(2'd0, 2'd0, ST, 2'd0, 26'd12, fill(8'h77), ALL, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 512'(l2rsp_valid), '0);
        for (int s = 0; s < 4; s++) rv_m[s] = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(2'd0, 2'd0, LD, 2'd0, 26'd12, '0, '0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request queue entries (power of two, at least 2).
REQ-002 SHALL have parameter LINE_COUNT, default 64, meaning backing lines, indexed by l2req_address[5:0].
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have request ports, all inputs unless noted: l2req_valid 1; l2req_ack out 1; l2req_strand 2; l2req_unit 2; l2req_op 3; l2req_way 2; l2req_address 26 (line address); l2req_data 512; l2req_mask 64 (byte enables).
REQ-005 SHALL have response ports, all outputs: l2rsp_valid 1; l2rsp_status 1; l2rsp_unit 2; l2rsp_strand 2; l2rsp_op 2; l2rsp_update 1; l2rsp_way 2; l2rsp_data 512.

Function
REQ-006 SHALL drive l2req_ack combinationally as l2req_valid && !fifo_full; a request is accepted in any cycle where both are high.
REQ-007 SHALL store each accepted request (strand, unit, op, way, address, data, mask) in the FIFO in arrival order, and SHALL never drop or reorder requests.
REQ-008 SHALL accept a push and a pop in the same cycle when the FIFO is full; l2req_ack still follows REQ-006 (low while full).
REQ-009 SHALL sequence through FSM states IDLE -> READ -> RESPOND -> IDLE. IDLE pops the FIFO head when it is non-empty and issues the line RAM read. READ captures the read data. RESPOND drives the response and performs any write.
REQ-010 SHALL assert l2rsp_valid for exactly one cycle per request, with no backpressure, 3 cycles after the accept cycle when the FSM is idle and the FIFO is empty (accept in cycle 0, response in cycle 3).
REQ-011 SHALL use these op encodings: 0 load, 1 store, 2 flush, 3 invalidate, 4 load_sync, 5 store_sync. For ops 6 and 7, SHALL respond with l2rsp_op=0, l2rsp_status=0 and make no state change.
REQ-012 SHALL map l2rsp_op as load/load_sync->0, store/store_sync->1, flush->2, invalidate->3.
REQ-013 SHALL echo l2rsp_unit, l2rsp_strand and l2rsp_way from the request.
REQ-014 SHALL merge store data bytewise: mask bit i selects byte data[8i+7:8i] from l2req_data, otherwise the old line byte.
REQ-015 SHALL return the merged line in l2rsp_data for a store, and the current line for all other ops.
REQ-016 SHALL hold one reservation per strand (valid bit plus 26-bit address). load_sync sets the reservation for the requesting strand to that address.
REQ-017 SHALL treat store_sync as successful only if the strand's reservation is valid and its address matches. On success it writes and returns status=1; on failure it makes no write and returns status=0.
REQ-018 SHALL clear every strand's reservation whose address matches on any successful write (store or successful store_sync), including the writer's own reservation.
REQ-019 SHALL return status=1 for load, store, flush, invalidate and load_sync.
REQ-020 SHALL set l2rsp_update=1 only for a response with l2rsp_op=1 and status=1.
REQ-021 SHALL make flush and invalidate leave the RAM and reservations unchanged.
REQ-022 SHALL make a request accepted in the same cycle as a write to the same line observe the post-write data.
REQ-023 SHALL give back-to-back requests to one line results identical to serial execution.

Reset
REQ-024 SHALL, while reset_n=0, force FSM=IDLE, FIFO empty, all reservations invalid, and l2rsp_valid, l2rsp_status, l2rsp_update, l2rsp_op, l2rsp_unit, l2rsp_strand and l2rsp_way all 0.
REQ-025 SHALL leave l2rsp_data and line RAM contents unspecified after reset.
REQ-026 SHALL abandon an in-flight request on reset mid-operation, with no response and no partial write.
REQ-027 SHALL hold l2req_ack=0 while reset_n=0.

Structure
REQ-028 SHALL place the op encodings, response-op encodings and FSM state constants in the shared L2 header used by the core and caches.
REQ-029 SHALL implement the backing store as a sub-module l2_line_ram: LINE_COUNT x 512 bits, synchronous 1-cycle read, single write port, write-before-read bypass.

Verification
REQ-030 SHALL cover reset then store (addr 5, all-ones mask, data 0xAA..) then load addr 5 -> store response update=1; load response data 0xAA.., op=0, status=1.
REQ-031 SHALL cover store with mask 0x1 (byte 0 = 0x55) onto line 0xAA.. -> response data byte 0 = 0x55 and all others 0xAA.
REQ-032 SHALL cover strand 1 load_sync addr 9 then store_sync addr 9 -> status=1, update=1. A repeat store_sync -> status=0, update=0, line unchanged.
REQ-033 SHALL cover strand 0 load_sync addr 3, then strand 2 store to addr 3, then strand 0 store_sync addr 3 -> status=0.
REQ-034 SHALL cover holding l2req_valid high for 8 requests with no gaps -> ack low once 4 are queued; 8 responses arrive in order, one every 3 cycles.
REQ-035 SHALL cover reset_n pulsed low in the READ state -> no l2rsp_valid for that request, FIFO empty, addressed line unmodified.
